mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequential arbiter that shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port and its data (memory-access stage) port. It registers the winning request, drives the memory handshake, and returns read data with a one-cycle valid pulse. It also produces per-port stall signals that freeze the fetch or memory stage. It sits between the core's IF/MEM stages and the unified memory, or the cache fill path.

## Interface
- AW, 32, address width
- DW, 32, data width (byte mask width = DW/8)
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits (fairness build only)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_valid
- if_addr  in  AW  fetch address
- if_valid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DW  fetched word
- if_stall  out  1  if_req & ~if_valid (combinational)
- d_req  in  1  data request; held with d_addr/d_we/d_wdata/d_wmask until d_valid
- d_addr  in  AW  data address
- d_we  in  1  1 = write
- d_wdata  in  DW  write data
- d_wmask  in  DW/8  byte enables for writes
- d_valid  out  1  one-cycle pulse; access complete
- d_rdata  out  DW  read data; 0 on write completion
- d_stall  out  1  d_req & ~d_valid (combinational)
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write strobe
- mem_addr  out  AW  registered address
- mem_wdata  out  DW  registered write data
- mem_wmask  out  DW/8  registered mask (all-zero on reads)
- mem_ready  in  1  memory completion; read data valid this cycle
- mem_rdata  in  DW  memory read data

## Operation
- FSM states: IDLE, BUSY, RESP. Owner register `gnt_d` (1 = data, 0 = fetch).
- IDLE: if any request is pending, grant it, latch its address, we, wdata and wmask into the mem_* registers, set mem_req=1, and go to BUSY. Otherwise stay in IDLE.
- Arbitration: d_req beats if_req, because the memory-stage instruction is older. Exception: the fairness rule in Configuration.
- BUSY: hold mem_* stable. On mem_ready, capture mem_rdata (or 0 for a write) into the owner's rdata register, clear mem_req, and go to RESP. Otherwise stay in BUSY with no limit.
- RESP: assert the owner's valid for exactly this cycle, then go to IDLE. No grant is made in RESP, so a requester that still holds req in the RESP cycle is not granted twice.
- The non-owner's rdata register keeps its value. Both valids are 0 outside RESP.
- A requester must drop req or present a new request in the cycle after its valid pulse. Changing req/addr before valid is illegal and unchecked.

## Timing
- Reset (asynchronous assert, synchronous release) gives: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0, if_valid=d_valid=0, if_rdata=d_rdata=0, starve_cnt=0.
- Minimum latency with mem_ready=1 on the first BUSY cycle:
  - req seen in cycle 0 (IDLE)
  - mem_req=1 in cycle 1 (BUSY)
  - valid in cycle 2 (RESP)
  - next grant possible in cycle 3
- General latency is 2 + (number of BUSY cycles). Throughput is one access per 3 cycles at best.
- Reset during BUSY drops mem_req immediately and abandons the access. The memory must tolerate the abandoned request. No valid pulse is produced for it.
- Both requests arrive in the same IDLE cycle: data wins, and fetch stalls at least 3 more cycles.
- Stalls are combinational from req and registered valid; there is no combinational path from mem_ready to any output.

## Configuration
- ARB_FAIRNESS_EN defined: adds `starve_cnt` (width clog2(STARVE_MAX+1)).
  - Increments, saturating, when data is granted while if_req=1.
  - Clears when fetch is granted.
  - In IDLE, if starve_cnt==STARVE_MAX and if_req=1, fetch wins over d_req.
- ARB_FAIRNESS_EN undefined: strict data priority. The counter logic is absent and fetch can starve indefinitely.

## Test plan
- Single fetch, mem_ready tied 1, if_addr=0x100, mem_rdata=0x00500093:
  - mem_req=1 with mem_addr=0x100 in cycle 1
  - if_valid pulse with if_rdata=0x00500093 in cycle 2
  - if_stall high in cycles 0–1
- Data write d_addr=0x40, d_wdata=0xDEADBEEF, d_wmask=4'b0011, mem_ready delayed 3 cycles:
  - mem_we=1 and mask 0011 held for 3 BUSY cycles
  - d_valid pulse with d_rdata=0
- Simultaneous if_req and d_req in IDLE: data is served first (d_valid in cycle 2), then fetch is granted in cycle 3 (if_valid in cycle 5).
- With ARB_FAIRNESS_EN and STARVE_MAX=4, d_req held continuously with if_req pending: the 5th grant goes to fetch. Without the macro, fetch is never granted.
- rst_n pulsed low during BUSY: mem_req=0 immediately, no valid pulse, state IDLE. A new fetch after release completes normally.
- Requester holds req through its RESP cycle: only one mem_req transaction is issued.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-ported variable-latency memory
//
// Shares one memory between the instruction-fetch port and the data port. The
// winning request is registered onto mem_*, held until mem_ready, and its
// result is returned with a one-cycle valid pulse on the owner's port.
//
// Optional build macro: ARB_FAIRNESS_EN. When defined, fetch is force-granted
// after STARVE_MAX consecutive data grants during which fetch was waiting.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_req/if_addr                 fetch request (held until if_valid)
//   if_valid/if_rdata/if_stall     fetch completion pulse, data, stall
//   d_req/d_addr/d_we/d_wdata/d_wmask  data request (held until d_valid)
//   d_valid/d_rdata/d_stall        data completion pulse, read data (0 on write), stall
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wmask  registered memory request
//   mem_ready/mem_rdata            memory completion and read data
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_valid,
  output logic [DW-1:0]   if_rdata,
  output logic            if_stall,
  input  logic            d_req,
  input  logic [AW-1:0]   d_addr,
  input  logic            d_we,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wmask,
  output logic            d_valid,
  output logic [DW-1:0]   d_rdata,
  output logic            d_stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   gnt_d;       // owner of the current access: 1 = data, 0 = fetch
  logic   grant_data;  // arbitration result, meaningful only when start is set
  logic   start;       // IDLE with a pending request: launch an access
  logic   complete;    // BUSY and memory finished this cycle

`ifdef ARB_FAIRNESS_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  logic [SW-1:0] starve_cnt;
`endif

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    complete   = 1'b0;
    // Data is the older instruction, so it normally wins.
    grant_data = d_req;
`ifdef ARB_FAIRNESS_EN
    if (starve_cnt == STARVE_LIM && if_req) begin
      grant_data = 1'b0;
    end
`endif
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          start     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          complete  = 1'b1;
          state_nxt = RESP;
        end
      end
      // No grant here: a requester still holding req during its valid cycle
      // must not be served a second time.
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_d     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if (start) begin
        gnt_d     <= grant_data;
        mem_req   <= 1'b1;
        mem_addr  <= grant_data ? d_addr : if_addr;
        mem_we    <= grant_data & d_we;
        mem_wdata <= grant_data ? d_wdata : '0;
        mem_wmask <= (grant_data && d_we) ? d_wmask : '0;
      end
      if (complete) begin
        mem_req <= 1'b0;
        if (gnt_d) begin
          d_rdata <= mem_we ? '0 : mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end
    end
  end

`ifdef ARB_FAIRNESS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (start) begin
      if (!grant_data) begin
        starve_cnt <= '0;
      end else if (if_req && starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`endif

  // Valids decode from registered state only, so mem_ready never reaches an output.
  assign if_valid = (state == RESP) && !gnt_d;
  assign d_valid  = (state == RESP) && gnt_d;
  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam logic [31:0] KEY = 32'h0050_0193;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_we;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int ready_lat = 0;
  int busy_cnt = 0;
  int txn = 0;
  logic mem_req_q = 1'b0;
  logic [31:0] exp_if[$];
  logic [31:0] exp_d[$];

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: read data is the address scrambled with KEY; ready after ready_lat waiting cycles.
  assign mem_rdata = mem_addr ^ KEY;
  assign mem_ready = mem_req && (busy_cnt >= ready_lat);

  always @(posedge clk) begin
    if (mem_req && !mem_ready) busy_cnt <= busy_cnt + 1;
    else busy_cnt <= 0;
  end

  // Scoreboard consumer and memory-transaction counter.
  always @(negedge clk) begin
    if (mem_req && !mem_req_q) txn = txn + 1;
    mem_req_q = mem_req;
    if (rst_n && if_valid) begin
      checks++;
      if (exp_if.size() == 0) begin
        errors++;
        $display("FAIL if_unexpected_valid actual rdata=%h required no pulse", if_rdata);
      end else begin
        logic [31:0] e;
        e = exp_if.pop_front();
        if (if_rdata !== e) begin
          errors++;
          $display("FAIL if_rdata actual=%h required=%h", if_rdata, e);
        end
      end
    end
    if (rst_n && d_valid) begin
      checks++;
      if (exp_d.size() == 0) begin
        errors++;
        $display("FAIL d_unexpected_valid actual rdata=%h required no pulse", d_rdata);
      end else begin
        logic [31:0] e;
        e = exp_d.pop_front();
        if (d_rdata !== e) begin
          errors++;
          $display("FAIL d_rdata actual=%h required=%h", d_rdata, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({mem_req, mem_we, if_valid, d_valid} !== 4'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        mem_wmask !== 4'h0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state actual req=%b we=%b addr=%h wd=%h wm=%h ifr=%h dr=%h ifv=%b dv=%b required all zero",
               mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, if_rdata, d_rdata, if_valid, d_valid);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    int t0;
    t0 = txn;
    ready_lat = 0;
    step();
    if_req = 1'b1; if_addr = 32'h100;
    exp_if.push_back(32'h0050_0093);
    @(negedge clk);
    checks++;
    if (if_stall !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL fetch_c0 actual stall=%b mem_req=%b required 1 0", if_stall, mem_req);
    end
    step();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || if_stall !== 1'b1) begin
      errors++;
      $display("FAIL fetch_c1 actual req=%b addr=%h we=%b stall=%b required 1 100 0 1", mem_req, mem_addr, mem_we, if_stall);
    end
    step();
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_stall !== 1'b0 || d_valid !== 1'b0) begin
      errors++; $display("FAIL fetch_c2 actual if_valid=%b stall=%b d_valid=%b required 1 0 0", if_valid, if_stall, d_valid);
    end
    step();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL fetch_c3 actual if_valid=%b mem_req=%b required 0 0", if_valid, mem_req);
    end
    step(); step();
    checks++;
    if (txn - t0 != 1) begin
      errors++; $display("FAIL hold_through_resp actual txns=%0d required 1", txn - t0);
    end
  endtask

  task automatic test_data_write();
    ready_lat = 2;
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011;
    exp_d.push_back(32'h0);
    for (int c = 1; c <= 3; c++) begin
      step();
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wmask !== 4'b0011 || mem_addr !== 32'h40 ||
          mem_wdata !== 32'hDEAD_BEEF || d_stall !== 1'b1 || d_valid !== 1'b0) begin
        errors++;
        $display("FAIL write_busy_c%0d actual req=%b we=%b wm=%b addr=%h wd=%h stall=%b required 1 1 0011 40 deadbeef 1",
                 c, mem_req, mem_we, mem_wmask, mem_addr, mem_wdata, d_stall);
      end
    end
    step();
    @(negedge clk);
    checks++;
    if (d_valid !== 1'b1 || d_stall !== 1'b0) begin
      errors++; $display("FAIL write_resp actual d_valid=%b stall=%b required 1 0", d_valid, d_stall);
    end
    step();
    d_req = 1'b0; d_we = 1'b0; ready_lat = 0;
  endtask

  task automatic test_simultaneous();
    ready_lat = 0;
    step();
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wmask = 4'hF;
    exp_d.push_back(32'h80 ^ KEY);
    exp_if.push_back(32'h200 ^ KEY);
    @(negedge clk);
    step();
    @(negedge clk);
    checks++;
    if (mem_addr !== 32'h80 || mem_wmask !== 4'h0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL simul_c1 actual addr=%h wm=%h we=%b required 80 0 0", mem_addr, mem_wmask, mem_we);
    end
    step();
    @(negedge clk);
    checks++;
    if (d_valid !== 1'b1 || if_valid !== 1'b0 || if_stall !== 1'b1) begin
      errors++; $display("FAIL simul_c2 actual d_valid=%b if_valid=%b if_stall=%b required 1 0 1", d_valid, if_valid, if_stall);
    end
    step();
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || if_stall !== 1'b1) begin
      errors++; $display("FAIL simul_c3 actual mem_req=%b if_stall=%b required 0 1", mem_req, if_stall);
    end
    step();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      errors++; $display("FAIL simul_c4 actual mem_req=%b addr=%h required 1 200", mem_req, mem_addr);
    end
    step();
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1) begin
      errors++; $display("FAIL simul_c5 actual if_valid=%b required 1", if_valid);
    end
    step();
    if_req = 1'b0;
  endtask

  task automatic test_fairness();
    int fetch_pos;
    int grant;
    bit got;
    fetch_pos = 0;
    grant = 0;
    ready_lat = 0;
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h480;
    if_req = 1'b1; if_addr = 32'h500;
`ifdef ARB_FAIRNESS_EN
    for (int i = 0; i < 4; i++) exp_d.push_back(32'h480 ^ KEY);
    exp_if.push_back(32'h500 ^ KEY);
`else
    for (int i = 0; i < 5; i++) exp_d.push_back(32'h480 ^ KEY);
`endif
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c % 3 == 1) begin
        grant++;
        if (mem_req === 1'b1 && mem_addr === 32'h500 && fetch_pos == 0) fetch_pos = grant;
      end
      step();
    end
    d_req = 1'b0;
`ifdef ARB_FAIRNESS_EN
    if_req = 1'b0;
    checks++;
    if (fetch_pos != 5) begin
      errors++; $display("FAIL fairness_grant actual fetch_grant=%0d required 5", fetch_pos);
    end
`else
    checks++;
    if (fetch_pos != 0) begin
      errors++; $display("FAIL strict_priority actual fetch_grant=%0d required 0 (never)", fetch_pos);
    end
    exp_if.push_back(32'h500 ^ KEY);
    got = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      @(negedge clk);
      if (if_valid) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL strict_fetch_after timeout actual no if_valid required pulse");
    end
    step();
    if_req = 1'b0;
`endif
    step();
  endtask

  task automatic test_reset_busy();
    bit got;
    ready_lat = 5;
    step();
    if_req = 1'b1; if_addr = 32'h300;
    step();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rst_busy_pre actual mem_req=%b required 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || if_valid !== 1'b0 || if_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_busy_async actual mem_req=%b addr=%h if_valid=%b if_rdata=%h required 0 0 0 0",
               mem_req, mem_addr, if_valid, if_rdata);
    end
    if_req = 1'b0; ready_lat = 0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || if_valid !== 1'b0) begin
        errors++; $display("FAIL rst_busy_idle actual mem_req=%b if_valid=%b required 0 0", mem_req, if_valid);
      end
    end
    step();
    if_req = 1'b1; if_addr = 32'h104;
    exp_if.push_back(32'h104 ^ KEY);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (if_valid) got = 1'b1;
      step();
    end
    if_req = 1'b0;
    checks++;
    if (!got) begin
      errors++; $display("FAIL rst_busy_new_fetch timeout actual no if_valid required pulse");
    end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual time limit reached required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_addr = '0; d_we = 1'b0; d_wdata = '0; d_wmask = '0;
    test_reset();
    test_single_fetch();
    test_data_write();
    test_simultaneous();
    test_fairness();
    test_reset_busy();
    step(); step();
    checks++;
    if (exp_if.size() != 0 || exp_d.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual pending if=%0d d=%0d required 0 0", exp_if.size(), exp_d.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
